glb_port_arbiter: RTL
=====================

Name: glb_port_arbiter

Overview:
- Shares one single-port GLB (one read or one write per cycle) between three clients: the iact router read port, the wght router read port and the psum router write port.
- Buffers one pending read per read client and arbitrates the two reads round-robin; psum writes always take priority.
- Tracks each in-flight read through a fixed-latency tag pipeline and steers the returned GLB data back to the requester that issued it.
- Sits between the router cluster and the GLB.

Parameters:
- DATA_BITWIDTH, 16, GLB word width.
- ADDR_BITWIDTH_GLB, 10, GLB address width.
- RD_LATENCY, 1, cycles from glb_req_read to valid glb_rdata; legal range 1..4.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  asynchronous active-low reset.
- iact_req_read  input  1  one-cycle read request pulse from the iact router.
- iact_addr_read  input  ADDR_BITWIDTH_GLB  iact read address; valid with iact_req_read.
- iact_data_o  output  DATA_BITWIDTH  read data returned to iact.
- iact_enable_o  output  1  one-cycle valid for iact_data_o.
- iact_busy_o  output  1  iact pending slot occupied.
- wght_req_read, wght_addr_read, wght_data_o, wght_enable_o, wght_busy_o  same widths and meanings, wght client.
- psum_write_en  input  1  psum write pulse; never stalled.
- psum_w_addr  input  ADDR_BITWIDTH_GLB  psum write address.
- psum_w_data  input  DATA_BITWIDTH  psum write data.
- glb_req_read  output  1  GLB read strobe.
- glb_addr_read  output  ADDR_BITWIDTH_GLB  GLB read address.
- glb_rdata  input  DATA_BITWIDTH  GLB read data, valid RD_LATENCY cycles after the strobe.
- glb_write_en  output  1  GLB write strobe.
- glb_w_addr  output  ADDR_BITWIDTH_GLB  GLB write address.
- glb_w_data  output  DATA_BITWIDTH  GLB write data.
- overflow_o  output  2  sticky drop flags; bit0 = iact, bit1 = wght.

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, pending slots empty, tag pipeline cleared, round-robin pointer = iact.
- Capture: req pulse with slot empty stores the address and sets busy on the next edge. A req into a full slot is dropped and sets the overflow bit; that bit clears only on reset.
- Issue (registered outputs, one GLB operation per cycle):
  - If psum_write_en=1, the next cycle drives glb_write_en=1 with the address and data registered. No read issues that cycle. Pending reads wait; their slots hold their contents.
  - Otherwise, if any slot is pending, issue one read. The winner is the client at the RR pointer if it is pending, else the other client.
  - On issue: glb_req_read=1 and glb_addr_read = slot address. The slot clears and busy drops on the same edge. The pointer moves to the non-winner.
  - Latency from req pulse to glb_req_read is 2 cycles when uncontended: capture, then issue.
- Same-cycle issue and capture for one client: a new req arriving in the cycle its slot issues is dropped and flagged, because the slot was still full when sampled.
- Return: each issued read pushes a 2-bit one-hot tag into a RD_LATENCY-deep shift register. When the tag reaches the end, glb_rdata is registered onto the tagged client's data_o with enable_o=1 for one cycle.
  - Total issue-to-enable_o = RD_LATENCY+1 cycles.
  - data_o holds its last value when enable_o=0.
- Back-to-back reads are allowed every cycle; the pipeline keeps their order.
- Reset mid-operation: in-flight tags are discarded and no enable_o fires afterwards.

Optional Feature:
- Macro: GLB_ARB_PERF_CNT_EN.
- When defined, adds output stall_cnt_o (16 bits, saturating). It increments every cycle in which at least one slot is pending and no read issues, whether because of a psum write or the one-issue limit. It resets to 0.
- When undefined, the port and the counter do not exist.

Test Plan:
- Single iact read, addr 0x005, RD_LATENCY=1, GLB returns 0xABCD → glb_req_read 2 cycles after the req; iact_enable_o=1 with 0xABCD 2 cycles later; wght_enable_o stays 0.
- iact and wght req in the same cycle after reset → iact issues first, wght the next cycle; the two returns arrive on consecutive cycles to the correct clients.
- psum_write_en held high for 3 cycles while iact is pending → 3 GLB writes with the given addr/data; the iact read issues on the 4th cycle; stall_cnt_o=3 when GLB_ARB_PERF_CNT_EN is defined.
- Two iact reqs in consecutive cycles while a psum write blocks issue → second req dropped; overflow_o=2'b01 and stays set.
- RD_LATENCY=3 with alternating iact/wght reads every cycle for 8 reads → each data word reaches its tagged client in order, 4 cycles after its issue.
- Reset asserted with 2 reads in flight → all outputs 0 immediately; no enable_o pulses after reset is released.

Source files
------------

// File: rtl/glb_port_arbiter.sv
// Shares one single-port GLB between the iact/wght read clients and the psum writer.
// Defining GLB_ARB_PERF_CNT_EN adds the saturating stall counter output stall_cnt_o.
module glb_port_arbiter #(
    parameter int DATA_BITWIDTH     = 16,
    parameter int ADDR_BITWIDTH_GLB = 10,
    parameter int RD_LATENCY        = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         iact_req_read,
    input  logic [ADDR_BITWIDTH_GLB-1:0] iact_addr_read,
    output logic [DATA_BITWIDTH-1:0]     iact_data_o,
    output logic                         iact_enable_o,
    output logic                         iact_busy_o,
    input  logic                         wght_req_read,
    input  logic [ADDR_BITWIDTH_GLB-1:0] wght_addr_read,
    output logic [DATA_BITWIDTH-1:0]     wght_data_o,
    output logic                         wght_enable_o,
    output logic                         wght_busy_o,
    input  logic                         psum_write_en,
    input  logic [ADDR_BITWIDTH_GLB-1:0] psum_w_addr,
    input  logic [DATA_BITWIDTH-1:0]     psum_w_data,
    output logic                         glb_req_read,
    output logic [ADDR_BITWIDTH_GLB-1:0] glb_addr_read,
    input  logic [DATA_BITWIDTH-1:0]     glb_rdata,
    output logic                         glb_write_en,
    output logic [ADDR_BITWIDTH_GLB-1:0] glb_w_addr,
    output logic [DATA_BITWIDTH-1:0]     glb_w_data,
`ifdef GLB_ARB_PERF_CNT_EN
    output logic [15:0]                  stall_cnt_o,
`endif
    output logic [1:0]                   overflow_o
);

    logic                         iact_pend_q, iact_pend_d;
    logic                         wght_pend_q, wght_pend_d;
    logic [ADDR_BITWIDTH_GLB-1:0] iact_addr_q, iact_addr_d;
    logic [ADDR_BITWIDTH_GLB-1:0] wght_addr_q, wght_addr_d;
    logic                         rr_q, rr_d;
    logic [1:0]                   overflow_q, overflow_d;

    logic                         glb_req_read_q, glb_req_read_d;
    logic [ADDR_BITWIDTH_GLB-1:0] glb_addr_read_q, glb_addr_read_d;
    logic                         glb_write_en_q, glb_write_en_d;
    logic [ADDR_BITWIDTH_GLB-1:0] glb_w_addr_q, glb_w_addr_d;
    logic [DATA_BITWIDTH-1:0]     glb_w_data_q, glb_w_data_d;

    // issue_tag_q is aligned with the GLB strobe; tag_q delays it to the data-valid cycle
    logic [1:0]                   issue_tag_q, issue_tag_d;
    logic [2*RD_LATENCY-1:0]      tag_q, tag_d;
    logic [1:0]                   ret_tag;

    logic [DATA_BITWIDTH-1:0]     iact_data_q, iact_data_d;
    logic [DATA_BITWIDTH-1:0]     wght_data_q, wght_data_d;
    logic                         iact_en_q, iact_en_d;
    logic                         wght_en_q, wght_en_d;

    logic any_pend, issue, win_wght, grant_iact, grant_wght;

    assign any_pend   = iact_pend_q | wght_pend_q;
    assign issue      = ~psum_write_en & any_pend;
    // rr_q = 0 favours iact, rr_q = 1 favours wght
    assign win_wght   = rr_q ? wght_pend_q : ~iact_pend_q;
    assign grant_iact = issue & ~win_wght;
    assign grant_wght = issue & win_wght;

    always_comb begin
        iact_pend_d     = iact_pend_q & ~grant_iact;
        wght_pend_d     = wght_pend_q & ~grant_wght;
        iact_addr_d     = iact_addr_q;
        wght_addr_d     = wght_addr_q;
        overflow_d      = overflow_q;
        rr_d            = issue ? ~win_wght : rr_q;
        glb_req_read_d  = issue;
        glb_addr_read_d = glb_addr_read_q;
        glb_write_en_d  = psum_write_en;
        glb_w_addr_d    = glb_w_addr_q;
        glb_w_data_d    = glb_w_data_q;
        issue_tag_d     = {grant_wght, grant_iact};

        // Fullness is judged on the registered slot, so a req landing in its issue cycle is dropped
        if (iact_req_read) begin
            if (iact_pend_q) begin
                overflow_d[0] = 1'b1;
            end else begin
                iact_pend_d = 1'b1;
                iact_addr_d = iact_addr_read;
            end
        end
        if (wght_req_read) begin
            if (wght_pend_q) begin
                overflow_d[1] = 1'b1;
            end else begin
                wght_pend_d = 1'b1;
                wght_addr_d = wght_addr_read;
            end
        end

        if (issue) begin
            glb_addr_read_d = win_wght ? wght_addr_q : iact_addr_q;
        end
        if (psum_write_en) begin
            glb_w_addr_d = psum_w_addr;
            glb_w_data_d = psum_w_data;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < RD_LATENCY; gi++) begin : g_tag
            if (gi == 0) begin : g_head
                assign tag_d[1:0] = issue_tag_q;
            end else begin : g_body
                assign tag_d[2*gi+1:2*gi] = tag_q[2*gi-1:2*gi-2];
            end
        end
    endgenerate

    assign ret_tag = tag_q[2*RD_LATENCY-1:2*RD_LATENCY-2];

    always_comb begin
        iact_en_d   = ret_tag[0];
        wght_en_d   = ret_tag[1];
        iact_data_d = ret_tag[0] ? glb_rdata : iact_data_q;
        wght_data_d = ret_tag[1] ? glb_rdata : wght_data_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            iact_pend_q     <= 1'b0;
            wght_pend_q     <= 1'b0;
            iact_addr_q     <= '0;
            wght_addr_q     <= '0;
            rr_q            <= 1'b0;
            overflow_q      <= '0;
            glb_req_read_q  <= 1'b0;
            glb_addr_read_q <= '0;
            glb_write_en_q  <= 1'b0;
            glb_w_addr_q    <= '0;
            glb_w_data_q    <= '0;
            issue_tag_q     <= '0;
            tag_q           <= '0;
            iact_data_q     <= '0;
            wght_data_q     <= '0;
            iact_en_q       <= 1'b0;
            wght_en_q       <= 1'b0;
        end else begin
            iact_pend_q     <= iact_pend_d;
            wght_pend_q     <= wght_pend_d;
            iact_addr_q     <= iact_addr_d;
            wght_addr_q     <= wght_addr_d;
            rr_q            <= rr_d;
            overflow_q      <= overflow_d;
            glb_req_read_q  <= glb_req_read_d;
            glb_addr_read_q <= glb_addr_read_d;
            glb_write_en_q  <= glb_write_en_d;
            glb_w_addr_q    <= glb_w_addr_d;
            glb_w_data_q    <= glb_w_data_d;
            issue_tag_q     <= issue_tag_d;
            tag_q           <= tag_d;
            iact_data_q     <= iact_data_d;
            wght_data_q     <= wght_data_d;
            iact_en_q       <= iact_en_d;
            wght_en_q       <= wght_en_d;
        end
    end

`ifdef GLB_ARB_PERF_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        stall;

    // A cycle stalls when some pending request is left waiting: psum holds the port or both slots compete
    assign stall = any_pend & (psum_write_en | (iact_pend_q & wght_pend_q));

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

    assign iact_data_o   = iact_data_q;
    assign iact_enable_o = iact_en_q;
    assign iact_busy_o   = iact_pend_q;
    assign wght_data_o   = wght_data_q;
    assign wght_enable_o = wght_en_q;
    assign wght_busy_o   = wght_pend_q;
    assign glb_req_read  = glb_req_read_q;
    assign glb_addr_read = glb_addr_read_q;
    assign glb_write_en  = glb_write_en_q;
    assign glb_w_addr    = glb_w_addr_q;
    assign glb_w_data    = glb_w_data_q;
    assign overflow_o    = overflow_q;

endmodule
